// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and its read-side drain controller.
package async_fifo_pkg;
  localparam int FIFO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;
endpackage

// File: rtl/fifo_reader_buf.sv
// Small circular buffer that absorbs the FIFO read latency ahead of the valid/ready output.
module fifo_reader_buf #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               head, tail;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];
endmodule

// File: rtl/async_fifo_reader.sv
// Read-domain drain controller: pops the FIFO, buffers the registered read data and
// streams it out as valid/ready, with enable/flush control and a delivered-word counter.
module async_fifo_reader
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 flush_i,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_empty_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 m_ready_i,
  output logic                 flush_done_o,
  output logic [CNT_WIDTH-1:0] rd_count_o
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t        state, state_nxt;
  logic          pending;
  logic          fdone_nxt;
  logic [CW-1:0] buf_count;
  logic          push, pop;

  always_comb begin
    state_nxt    = state;
    fdone_nxt    = 1'b0;
    fifo_rd_en_o = 1'b0;
    case (state)
      IDLE: if (enable_i) state_nxt = RUN;
      RUN: begin
        if (!enable_i) state_nxt = IDLE;
        // Words already in flight count against buffer space; no pop in the flush-done cycle.
        fifo_rd_en_o = ~fifo_empty_i & ~flush_done_o &
                       ((int'(buf_count) + int'(pending)) < BUF_DEPTH);
      end
      FLUSH: begin
        fifo_rd_en_o = ~fifo_empty_i;
        if (!flush_i && fifo_empty_i && !pending) begin
          state_nxt = enable_i ? RUN : IDLE;
          fdone_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = FLUSH;
    if (rst_i) fifo_rd_en_o = 1'b0;
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pending      <= 1'b0;
      flush_done_o <= 1'b0;
      rd_count_o   <= '0;
    end else begin
      state        <= state_nxt;
      pending      <= fifo_rd_en_o;
      flush_done_o <= fdone_nxt;
      if (m_valid_o && m_ready_i) rd_count_o <= rd_count_o + CNT_WIDTH'(1);
    end
  end

  // Data arriving while flushing is dropped rather than buffered.
  assign push      = pending & (state != FLUSH) & ~flush_i;
  assign pop       = m_valid_o & m_ready_i;
  assign m_valid_o = (buf_count != '0);

  fifo_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk_i),
    .rst       (rst_i),
    .clr       (flush_i),
    .push      (push),
    .push_data (fifo_rdata_i),
    .pop       (pop),
    .head_data (m_data_o),
    .count     (buf_count)
  );
endmodule

// File: tb/tb_async_fifo_reader.sv
// Bench for async_fifo_reader: FIFO read-port model plus an ordered scoreboard of popped words.
module tb_async_fifo_reader;
  localparam int WIDTH = 8, BUF_DEPTH = 3, CNT_WIDTH = 16;

  logic                 rd_clk_i = 1'b0;
  logic                 rst_i = 1'b1, enable_i = 1'b0, flush_i = 1'b0, m_ready_i = 1'b0;
  logic                 gap = 1'b0;
  logic [WIDTH-1:0]     fifo_rdata_i = '0;
  logic                 fifo_empty_i;
  logic                 fifo_rd_en_o, m_valid_o, flush_done_o;
  logic [WIDTH-1:0]     m_data_o;
  logic [CNT_WIDTH-1:0] rd_count_o;

  int n_checks = 0, n_errors = 0;
  logic [7:0] mem [4096];
  int wr_idx = 0, rd_idx = 0;
  logic [7:0] exp_q [$];
  int delivered = 0, pop_cnt = 0, fdone_cnt = 0, cyc = 0, first_valid = -1, last_deliv = -1;
  bit discarding = 1'b0, prev_fdone = 1'b0;

  assign fifo_empty_i = gap | (wr_idx == rd_idx);

  async_fifo_reader #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .rd_clk_i     (rd_clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_empty_i (fifo_empty_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_ready_i    (m_ready_i),
    .flush_done_o (flush_done_o),
    .rd_count_o   (rd_count_o)
  );

  always #5 rd_clk_i = ~rd_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_idx % 4096] = w;
    wr_idx++;
  endtask

  // One clock: observe at the falling edge, then apply the FIFO/scoreboard effects of the rising edge.
  task automatic tick();
    logic s_rst, s_flush, s_fdone, s_pop, s_hs;
    @(negedge rd_clk_i);
    cyc++;
    s_rst   = rst_i;
    s_flush = flush_i;
    s_fdone = flush_done_o;
    s_pop   = fifo_rd_en_o;
    s_hs    = m_valid_o & m_ready_i;
    if (s_rst) chk("rd_en_in_reset", {31'd0, fifo_rd_en_o}, 0);
    if (s_pop) chk("pop_while_empty", {31'd0, fifo_empty_i}, 0);
    if (s_fdone) begin
      chk("fdone_width", {31'd0, prev_fdone}, 0);
      fdone_cnt++;
    end
    prev_fdone = s_fdone;
    if (m_valid_o) begin
      if (first_valid < 0) first_valid = cyc;
      if (discarding) chk("valid_during_flush", {31'd0, m_valid_o}, 0);
      else if (exp_q.size() == 0) chk("spurious_valid", {31'd0, m_valid_o}, 0);
      else chk("data", {24'd0, m_data_o}, {24'd0, exp_q[0]});
    end
    if (s_hs) last_deliv = cyc;
    @(posedge rd_clk_i);
    #1;
    if (s_hs) begin
      delivered++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (s_rst) begin
      exp_q.delete();
      discarding = 1'b0;
      delivered  = 0;
    end else begin
      if (s_fdone) discarding = 1'b0;
      if (s_flush) begin
        exp_q.delete();
        discarding = 1'b1;
      end
    end
    if (s_pop && rd_idx != wr_idx) begin
      pop_cnt++;
      fifo_rdata_i = mem[rd_idx % 4096];
      if (!discarding && !s_rst) exp_q.push_back(fifo_rdata_i);
      rd_idx++;
    end else begin
      fifo_rdata_i = 8'($urandom);
    end
  endtask

  task automatic drain(input int max, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wr_idx != rd_idx || m_valid_o || discarding) && n < max) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size() + (wr_idx - rd_idx) + int'(m_valid_o), 0);
  endtask

  initial begin
    int cs, p0, d0, f0, n;
    // Reset with a non-empty FIFO
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    repeat (2) tick();
    rst_i = 1'b0;
    chk("reset_valid", {31'd0, m_valid_o}, 0);
    chk("reset_fdone", {31'd0, flush_done_o}, 0);
    chk("reset_count", {16'd0, rd_count_o}, 0);

    // Streaming 0x01..0x10
    enable_i = 1'b1; m_ready_i = 1'b1;
    first_valid = -1; cs = cyc; n = 0;
    while (delivered < 16 && n < 60) begin tick(); n++; end
    chk("first_valid_latency", first_valid - cs - 1, 3);
    chk("burst_span", last_deliv - first_valid, 15);
    chk("rd_count_stream", {16'd0, rd_count_o}, 16);

    // Backpressure
    m_ready_i = 1'b0;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    p0 = pop_cnt;
    repeat (12) tick();
    chk("bp_pops", pop_cnt - p0, 3);
    chk("bp_valid", {31'd0, m_valid_o}, 1);
    chk("bp_hold", {24'd0, m_data_o}, 32'h01);
    m_ready_i = 1'b1;
    drain(100, "bp_drain");
    chk("rd_count_bp", {16'd0, rd_count_o}, 32);

    // Flush mid-stream after 5 words
    for (int i = 0; i < 16; i++) push_word(8'(8'h21 + i));
    n = 0;
    while (delivered < 37 && n < 40) begin tick(); n++; end
    m_ready_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; m_ready_i = 1'b1;
    f0 = fdone_cnt;
    repeat (30) tick();
    chk("flush_pulses", fdone_cnt - f0, 1);
    chk("flush_drained", wr_idx - rd_idx, 0);
    chk("rd_count_flush", {16'd0, rd_count_o}, 37);
    push_word(8'h55);
    d0 = delivered; n = 0;
    while (delivered == d0 && n < 10) begin tick(); n++; end
    chk("after_flush_word", delivered - d0, 1);

    // Enable drop in the same cycle as a pop
    enable_i = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) push_word(8'(8'h61 + i));
    p0 = pop_cnt;
    repeat (3) tick();
    chk("idle_no_pop", pop_cnt - p0, 0);
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    p0 = pop_cnt; d0 = delivered;
    repeat (12) tick();
    chk("drop_pops", pop_cnt - p0, 1);
    chk("drop_deliv", delivered - d0, 1);
    enable_i = 1'b1;
    drain(60, "drop_drain");
    chk("rd_count_drop", {16'd0, rd_count_o}, 44);

    // Reset with words buffered and in flight
    m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'(8'h71 + i));
    p0 = pop_cnt; n = 0;
    while (pop_cnt - p0 < 3 && n < 10) begin tick(); n++; end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_valid", {31'd0, m_valid_o}, 0);
    chk("mid_rst_count", {16'd0, rd_count_o}, 0);
    m_ready_i = 1'b1;
    drain(60, "mid_rst_drain");
    chk("rd_count_after_rst", {16'd0, rd_count_o}, 7);

    // Randomized traffic with gaps, backpressure, enable toggles and flushes
    for (int i = 0; i < 800; i++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      gap       = ($urandom_range(0, 4) == 0);
      flush_i   = ($urandom_range(0, 89) == 0);
      if ($urandom_range(0, 59) == 0) enable_i = ~enable_i;
      if ($urandom_range(0, 2) == 0) push_word(8'($urandom));
      tick();
    end
    flush_i = 1'b0; gap = 1'b0; enable_i = 1'b1; m_ready_i = 1'b1;
    drain(3000, "rand_drain");
    chk("rd_count_final", {16'd0, rd_count_o}, delivered & 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
